// File: rtl/dense_result_collector.sv
// Result collector for the dense-dense multiplier: buffers the unthrottled pair stream,
// tags each pair with its (row, col) position and presents it on a ready/valid port.
module dense_result_collector #(
    parameter int unsigned N     = 560,
    parameter int unsigned DEPTH = 16,
    parameter int unsigned DW    = 64
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     in_valid,
    input  logic [DW-1:0]            in_data1,
    input  logic [DW-1:0]            in_data2,
    output logic                     out_valid,
    input  logic                     out_ready,
    output logic [DW-1:0]            out_data1,
    output logic [DW-1:0]            out_data2,
    output logic [$clog2(N)-1:0]     out_row,
    output logic [$clog2(N)-1:0]     out_col,
    output logic                     out_last_row,
    output logic                     out_last,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     overflow,
    output logic                     done
);

    localparam int unsigned RW   = $clog2(N);
    localparam int unsigned CW   = RW;
    localparam int unsigned AW   = $clog2(DEPTH);
    localparam int unsigned CNTW = AW + 1;

    logic [DW-1:0]   mem_d1  [DEPTH];
    logic [DW-1:0]   mem_d2  [DEPTH];
    logic [RW-1:0]   mem_row [DEPTH];
    logic [CW-1:0]   mem_col [DEPTH];

    logic [AW-1:0]   wr_ptr;
    logic [AW-1:0]   rd_ptr;
    logic [RW-1:0]   wr_row;
    logic [CW-1:0]   wr_col;

    logic            push;
    logic            pop;
    logic            head_last_row;
    logic            head_last;
    logic [CNTW-1:0] count_next;

    // Handshake decode; a full FIFO still accepts when the head leaves this cycle
    always_comb begin
        pop        = 1'b0;
        push       = 1'b0;
        count_next = count;
        pop        = out_valid && out_ready;
        push       = in_valid && ((count < CNTW'(DEPTH)) || pop);
        count_next = count + CNTW'(push) - CNTW'(pop);
    end

    always_comb begin
        head_last_row = 1'b0;
        head_last     = 1'b0;
        head_last_row = (mem_col[rd_ptr] == CW'(N - 2));
        head_last     = head_last_row && (mem_row[rd_ptr] == RW'(N - 1));
    end

    // Payload is forced to zero whenever the head is not valid
    assign out_data1    = out_valid ? mem_d1[rd_ptr]  : '0;
    assign out_data2    = out_valid ? mem_d2[rd_ptr]  : '0;
    assign out_row      = out_valid ? mem_row[rd_ptr] : '0;
    assign out_col      = out_valid ? mem_col[rd_ptr] : '0;
    assign out_last_row = out_valid && head_last_row;
    assign out_last     = out_valid && head_last;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            out_valid <= 1'b0;
            count     <= '0;
            overflow  <= 1'b0;
            done      <= 1'b0;
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            wr_row    <= '0;
            wr_col    <= '0;
        end else begin
            count     <= count_next;
            out_valid <= (count_next != '0);
            done      <= pop && head_last;
            if (in_valid && !push) begin
                overflow <= 1'b1;
            end
            if (push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + AW'(1);
            end
            // Tags follow every input pair, dropped or not, to stay matrix-aligned
            if (in_valid) begin
                if (wr_col == CW'(N - 2)) begin
                    wr_col <= '0;
                    wr_row <= (wr_row == RW'(N - 1)) ? '0 : wr_row + RW'(1);
                end else begin
                    wr_col <= wr_col + CW'(2);
                end
            end
        end
    end

    // Storage is intentionally not reset
    always_ff @(posedge clk) begin
        if (push) begin
            mem_d1[wr_ptr]  <= in_data1;
            mem_d2[wr_ptr]  <= in_data2;
            mem_row[wr_ptr] <= wr_row;
            mem_col[wr_ptr] <= wr_col;
        end
    end

endmodule
